clock_set_ctl: RTL

- Time-set controller for the digital clock.
- Takes two raw pushbuttons (mode, up) and sequences the clock core through RUN, SET_HR and SET_MIN.
- Issues single-cycle hour/minute advance pulses with hold-to-auto-repeat, a seconds-clear pulse, and a per-digit blank mask that lets the seven-segment controller blink the field being edited.
- Sits between the board buttons and the clock core / display controller.

---
 rtl/clock_set_ctl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/clock_set_ctl.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_ctl
// Brief    : Time-set controller for the digital clock. Conditions two raw
//            buttons and sequences RUN -> SET_HR -> SET_MIN with auto-repeat
//            advance pulses, a seconds-clear pulse and a blink mask.
// Revision : 1.0 - initial release
// ============================================================================
module clock_set_ctl #(
    parameter int unsigned DB_CYCLES      = 1_000_000,
    parameter int unsigned HOLD_CYCLES    = 50_000_000,
    parameter int unsigned RPT_CYCLES     = 10_000_000,
    parameter int unsigned BLINK_CYCLES   = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic       adv_hr,
    output logic       adv_min,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic [7:0] blank_mask
);

    localparam int unsigned c_RPT_MAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;

    localparam int c_DB_W    = $clog2(DB_CYCLES + 1);
    localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);
    localparam int c_BLINK_W = $clog2(BLINK_CYCLES + 1);
    localparam int c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_DB_W-1:0]    c_DB_LAST    = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_RPT_W-1:0]   c_HOLD_LAST  = c_RPT_W'(HOLD_CYCLES - 1);
    localparam logic [c_RPT_W-1:0]   c_RPT_LAST   = c_RPT_W'(RPT_CYCLES - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [c_TO_W-1:0]    c_TO_LAST    = c_TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    // ------------------------------------------------------------------------
    // Button conditioning: index 0 = mode, index 1 = up
    // ------------------------------------------------------------------------
    logic [1:0] w_btn_raw;
    logic [1:0] w_level;
    logic [1:0] w_press;

    assign w_btn_raw = {btn_up, btn_mode};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic              r_sync1;
        logic              r_sync2;
        logic              r_level;
        logic              r_level_d;
        logic              r_press;
        logic [c_DB_W-1:0] r_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_level   <= 1'b0;
                r_level_d <= 1'b0;
                r_press   <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_sync1   <= w_btn_raw[gi];
                r_sync2   <= r_sync1;
                r_level_d <= r_level;
                r_press   <= r_level & ~r_level_d;
                // Level follows the input only after DB_CYCLES consecutive disagreements
                if (r_sync2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt >= c_DB_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_level[gi] = r_level;
        assign w_press[gi] = r_press;
    end

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    state_t                 r_state;
    logic [c_TO_W-1:0]      r_to_cnt;
    logic [c_RPT_W-1:0]     r_rpt_cnt;
    logic                   r_rpt_on;
    logic                   r_rpt_hold;
    logic [c_BLINK_W-1:0]   r_blink_cnt;
    logic                   r_blank;

    state_t                 w_state_nxt;
    logic                   w_state_chg;
    logic                   w_in_set;
    logic                   w_mode_press;
    logic                   w_up_press;
    logic                   w_up_level;
    logic                   w_sec_clr_nxt;
    logic                   w_adv;
    logic [c_TO_W-1:0]      w_to_cnt_nxt;
    logic [c_RPT_W-1:0]     w_rpt_cnt_nxt;
    logic                   w_rpt_on_nxt;
    logic                   w_rpt_hold_nxt;
    logic [c_BLINK_W-1:0]   w_blink_cnt_nxt;
    logic                   w_blank_nxt;
    logic [7:0]             w_mask_nxt;

    assign w_mode_press = w_press[0];
    assign w_up_press   = w_press[1];
    assign w_up_level   = w_level[1];

    always_comb begin
        w_state_nxt     = r_state;
        w_state_chg     = 1'b0;
        w_sec_clr_nxt   = 1'b0;
        w_adv           = 1'b0;
        w_to_cnt_nxt    = r_to_cnt;
        w_rpt_cnt_nxt   = r_rpt_cnt;
        w_rpt_on_nxt    = r_rpt_on;
        w_rpt_hold_nxt  = r_rpt_hold;
        w_blink_cnt_nxt = r_blink_cnt;
        w_blank_nxt     = r_blank;
        w_mask_nxt      = '0;
        w_in_set        = (r_state != ST_RUN);

        if (w_mode_press) begin
            case (r_state)
                ST_RUN:    w_state_nxt = ST_SET_HR;
                ST_SET_HR: w_state_nxt = ST_SET_MIN;
                default: begin
                    w_state_nxt   = ST_RUN;
                    w_sec_clr_nxt = (r_state == ST_SET_MIN);
                end
            endcase
        end else if (w_in_set && (r_to_cnt >= c_TO_LAST)) begin
            w_state_nxt = ST_RUN;
        end
        w_state_chg = (w_state_nxt != r_state);

        if (!w_in_set || w_state_chg || w_mode_press || w_up_press) begin
            w_to_cnt_nxt = '0;
        end else if (r_to_cnt < c_TO_LAST) begin
            w_to_cnt_nxt = r_to_cnt + 1'b1;
        end

        // Any state change kills repeat; only a fresh up press can re-arm it
        if (!w_in_set || w_state_chg) begin
            w_rpt_on_nxt  = 1'b0;
            w_rpt_cnt_nxt = '0;
        end else if (w_up_press) begin
            w_adv          = 1'b1;
            w_rpt_on_nxt   = 1'b1;
            w_rpt_hold_nxt = 1'b1;
            w_rpt_cnt_nxt  = '0;
        end else if (r_rpt_on && !w_up_level) begin
            w_rpt_on_nxt  = 1'b0;
            w_rpt_cnt_nxt = '0;
        end else if (r_rpt_on) begin
            if ((r_rpt_hold && (r_rpt_cnt >= c_HOLD_LAST)) ||
                (!r_rpt_hold && (r_rpt_cnt >= c_RPT_LAST))) begin
                w_adv          = 1'b1;
                w_rpt_hold_nxt = 1'b0;
                w_rpt_cnt_nxt  = '0;
            end else if (r_rpt_cnt < c_HOLD_LAST || r_rpt_cnt < c_RPT_LAST) begin
                w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
            end
        end

        if ((w_state_nxt == ST_RUN) || w_state_chg || w_adv) begin
            w_blank_nxt     = 1'b0;
            w_blink_cnt_nxt = '0;
        end else if (r_blink_cnt >= c_BLINK_LAST) begin
            w_blank_nxt     = ~r_blank;
            w_blink_cnt_nxt = '0;
        end else begin
            w_blink_cnt_nxt = r_blink_cnt + 1'b1;
        end

        case (w_state_nxt)
            ST_SET_HR:  w_mask_nxt = {{2{w_blank_nxt}}, 6'b00_0000};
            ST_SET_MIN: w_mask_nxt = {2'b00, {2{w_blank_nxt}}, 4'b0000};
            default:    w_mask_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_to_cnt    <= '0;
            r_rpt_cnt   <= '0;
            r_rpt_on    <= 1'b0;
            r_rpt_hold  <= 1'b0;
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
            adv_hr      <= 1'b0;
            adv_min     <= 1'b0;
            sec_clr     <= 1'b0;
            blank_mask  <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_rpt_cnt   <= w_rpt_cnt_nxt;
            r_rpt_on    <= w_rpt_on_nxt;
            r_rpt_hold  <= w_rpt_hold_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blank     <= w_blank_nxt;
            adv_hr      <= w_adv && (r_state == ST_SET_HR);
            adv_min     <= w_adv && (r_state == ST_SET_MIN);
            sec_clr     <= w_sec_clr_nxt;
            blank_mask  <= w_mask_nxt;
        end
    end

    assign mode = r_state;

endmodule
`default_nettype wire
